// File: rtl/vx_dcache_req_arb.sv
// vx_dcache_req_arb: merges NUM_INPUTS request bundles onto one NUM_REQS-lane
// dcache request port. Each input has its own bundle FIFO. Non-empty FIFOs are
// served round-robin. The winning input index is prepended to the tag so the
// response path can route the reply back to the right requester.
// Optional: define VX_DCACHE_REQ_ARB_PERF_EN to add stall/bundle counters.

// Per-input bundle FIFO; storage is left unreset, only pointers/occupancy reset.
module vx_dcache_req_arb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;

  // pointer and occupancy tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop)  r_rp <= r_rp + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // bundle storage
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_data;
  end

  assign o_data  = r_mem[r_rp];
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
endmodule

module vx_dcache_req_arb #(
  parameter int NUM_INPUTS   = 4,
  parameter int NUM_REQS     = 4,
  parameter int WORD_SIZE    = 4,
  parameter int ADDR_WIDTH   = 30,
  parameter int TAG_IN_WIDTH = 8,
  parameter int BUF_DEPTH    = 2,
  localparam int SEL_BITS      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_INPUTS-1:0]                        in_valid,
  input  logic [NUM_INPUTS*NUM_REQS-1:0]               in_lane_mask,
  input  logic [NUM_INPUTS*NUM_REQS-1:0]               in_rw,
  input  logic [NUM_INPUTS*NUM_REQS*WORD_SIZE-1:0]     in_byteen,
  input  logic [NUM_INPUTS*NUM_REQS*ADDR_WIDTH-1:0]    in_addr,
  input  logic [NUM_INPUTS*NUM_REQS*WORD_SIZE*8-1:0]   in_data,
  input  logic [NUM_INPUTS*TAG_IN_WIDTH-1:0]           in_tag,
  output logic [NUM_INPUTS-1:0]                        in_ready,
  output logic [NUM_REQS-1:0]                          out_valid,
  output logic [NUM_REQS-1:0]                          out_rw,
  output logic [NUM_REQS*WORD_SIZE-1:0]                out_byteen,
  output logic [NUM_REQS*ADDR_WIDTH-1:0]               out_addr,
  output logic [NUM_REQS*WORD_SIZE*8-1:0]              out_data,
  output logic [NUM_REQS*TAG_OUT_WIDTH-1:0]            out_tag,
`ifdef VX_DCACHE_REQ_ARB_PERF_EN
  output logic [63:0]                                  perf_stall_cycles,
  output logic [63:0]                                  perf_bundles,
`endif
  input  logic [NUM_REQS-1:0]                          out_ready
);
  // bundle entry layout: {tag, data, addr, byteen, rw, mask}
  localparam int MASK_LO = 0;
  localparam int RW_LO   = MASK_LO + NUM_REQS;
  localparam int BE_LO   = RW_LO + NUM_REQS;
  localparam int AD_LO   = BE_LO + NUM_REQS*WORD_SIZE;
  localparam int DA_LO   = AD_LO + NUM_REQS*ADDR_WIDTH;
  localparam int TG_LO   = DA_LO + NUM_REQS*WORD_SIZE*8;
  localparam int ENT_W   = TG_LO + TAG_IN_WIDTH;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t                               r_state;
  logic [NUM_REQS-1:0]                  r_sent;
  logic [SEL_BITS-1:0]                  r_rr, r_cur_sel;

  logic [NUM_INPUTS-1:0][ENT_W-1:0]     w_din, w_head;
  logic [NUM_INPUTS-1:0]                w_push, w_pop, w_empty, w_full;
  logic [ENT_W-1:0]                     w_ent;
  logic [SEL_BITS-1:0]                  w_grant, w_hi, w_lo, w_sel;
  logic                                 w_hi_any, w_any, w_act, w_done;
  logic [NUM_REQS-1:0]                  w_mask, w_acc;

  // ready is gated by reset so nothing is accepted while held in reset
  assign in_ready = ~w_full & {NUM_INPUTS{reset}};

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
    // zero-mask bundles are accepted but dropped here
    assign w_push[i] = in_valid[i] & in_ready[i] & (|in_lane_mask[i*NUM_REQS +: NUM_REQS]);
    assign w_din[i]  = {in_tag[i*TAG_IN_WIDTH +: TAG_IN_WIDTH],
                        in_data[i*NUM_REQS*WORD_SIZE*8 +: NUM_REQS*WORD_SIZE*8],
                        in_addr[i*NUM_REQS*ADDR_WIDTH +: NUM_REQS*ADDR_WIDTH],
                        in_byteen[i*NUM_REQS*WORD_SIZE +: NUM_REQS*WORD_SIZE],
                        in_rw[i*NUM_REQS +: NUM_REQS],
                        in_lane_mask[i*NUM_REQS +: NUM_REQS]};
    vx_dcache_req_arb_fifo #(.W(ENT_W), .DEPTH(BUF_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push[i]),
      .i_pop   (w_pop[i]),
      .i_data  (w_din[i]),
      .o_data  (w_head[i]),
      .o_empty (w_empty[i]),
      .o_full  (w_full[i])
    );
  end

  // round-robin pick: lowest non-empty index >= rr, else lowest non-empty overall
  always_comb begin
    w_hi     = '0;
    w_lo     = '0;
    w_hi_any = 1'b0;
    w_any    = 1'b0;
    for (int j = NUM_INPUTS-1; j >= 0; j--) begin
      if (!w_empty[j]) begin
        w_lo  = SEL_BITS'(j);
        w_any = 1'b1;
        if (SEL_BITS'(j) >= r_rr) begin
          w_hi     = SEL_BITS'(j);
          w_hi_any = 1'b1;
        end
      end
    end
    w_grant = w_hi_any ? w_hi : w_lo;
  end

  // grant is frozen while a bundle is partially sent
  assign w_sel = (r_state == S_HOLD) ? r_cur_sel : w_grant;
  assign w_act = (r_state == S_HOLD) | w_any;

  // head mux and retire pop
  always_comb begin
    w_ent = '0;
    w_pop = '0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      if (SEL_BITS'(j) == w_sel) begin
        w_ent    = w_head[j];
        w_pop[j] = w_done;
      end
    end
  end

  assign w_mask     = w_ent[MASK_LO +: NUM_REQS];
  assign out_valid  = w_act ? (w_mask & ~r_sent) : '0;
  assign w_acc      = out_valid & out_ready;
  assign w_done     = w_act & ((r_sent | w_acc) == w_mask);
  assign out_rw     = w_ent[RW_LO +: NUM_REQS];
  assign out_byteen = w_ent[BE_LO +: NUM_REQS*WORD_SIZE];
  assign out_addr   = w_ent[AD_LO +: NUM_REQS*ADDR_WIDTH];
  assign out_data   = w_ent[DA_LO +: NUM_REQS*WORD_SIZE*8];

  for (genvar l = 0; l < NUM_REQS; l++) begin : g_tag
    assign out_tag[l*TAG_OUT_WIDTH +: TAG_OUT_WIDTH] = {w_sel, w_ent[TG_LO +: TAG_IN_WIDTH]};
  end

  // IDLE/HOLD control: retire on full coverage, otherwise hold and track sent lanes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_sent    <= '0;
      r_rr      <= '0;
      r_cur_sel <= '0;
    end else if (w_done) begin
      r_state <= S_IDLE;
      r_sent  <= '0;
      r_rr    <= (w_sel == SEL_BITS'(NUM_INPUTS-1)) ? '0 : w_sel + 1'b1;
    end else if (w_act) begin
      r_state   <= S_HOLD;
      r_cur_sel <= w_sel;
      r_sent    <= r_sent | w_acc;
    end
  end

`ifdef VX_DCACHE_REQ_ARB_PERF_EN
  logic w_stall;
  assign w_stall = |(out_valid & ~out_ready);

  // saturating performance counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles <= '0;
      perf_bundles      <= '0;
    end else begin
      if (w_stall && (perf_stall_cycles != '1)) perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (w_done && (perf_bundles != '1))       perf_bundles      <= perf_bundles + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_vx_dcache_req_arb.sv
// Directed bench for vx_dcache_req_arb at default parameters.
module tb_vx_dcache_req_arb;
  localparam int NI = 4, NR = 4, WS = 4, AW = 30, TW = 8, TOW = 10;

  logic               clk, reset;
  logic [NI-1:0]      in_valid, in_ready;
  logic [NI*NR-1:0]   in_lane_mask, in_rw;
  logic [NI*NR*WS-1:0] in_byteen;
  logic [NI*NR*AW-1:0] in_addr;
  logic [NI*NR*WS*8-1:0] in_data;
  logic [NI*TW-1:0]   in_tag;
  logic [NR-1:0]      out_valid, out_rw, out_ready;
  logic [NR*WS-1:0]   out_byteen;
  logic [NR*AW-1:0]   out_addr;
  logic [NR*WS*8-1:0] out_data;
  logic [NR*TOW-1:0]  out_tag;
`ifdef VX_DCACHE_REQ_ARB_PERF_EN
  logic [63:0]        perf_stall_cycles, perf_bundles;
`endif

  vx_dcache_req_arb dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_lane_mask(in_lane_mask),
    .in_rw(in_rw), .in_byteen(in_byteen), .in_addr(in_addr), .in_data(in_data),
    .in_tag(in_tag), .in_ready(in_ready), .out_valid(out_valid), .out_rw(out_rw),
    .out_byteen(out_byteen), .out_addr(out_addr), .out_data(out_data),
    .out_tag(out_tag),
`ifdef VX_DCACHE_REQ_ARB_PERF_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_bundles(perf_bundles),
`endif
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;

  typedef struct {
    logic [3:0] iv, ordy, ov, ir;
    logic [1:0] sel;
  } vec_t;
  vec_t tv[8];

  function automatic logic [AW-1:0] f_addr(int i, int l, logic [7:0] t);
    return {t, 4'(i), 4'(l), 14'h01A5};
  endfunction
  function automatic logic [31:0] f_data(int i, int l, logic [7:0] t);
    return {t, 8'(i), 8'(l), 8'hC3};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic [3:0] m, input logic [7:0] t, input logic v);
    in_valid[i] = v;
    in_lane_mask[i*NR +: NR] = m;
    in_tag[i*TW +: TW] = t;
    for (int l = 0; l < NR; l++) begin
      in_rw[i*NR+l] = l[0];
      in_byteen[(i*NR+l)*WS +: WS] = 4'(i + l + 1);
      in_addr[(i*NR+l)*AW +: AW] = f_addr(i, l, t);
      in_data[(i*NR+l)*32 +: 32] = f_data(i, l, t);
    end
  endtask

  initial begin
    reset = 1'b0;
    in_valid = '0; in_lane_mask = '0; in_rw = '0; in_byteen = '0;
    in_addr = '0; in_data = '0; in_tag = '0; out_ready = '0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    step(); step();
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'hF);

    // single bundle, one-cycle latency, tag prefix
    set_in(2, 4'b1011, 8'h5A, 1'b1);
    out_ready = 4'hF;
    #1;
    chk("no_bypass", 64'(out_valid), 64'h0);
    step();
    in_valid = '0;
    #1;
    chk("single_valid", 64'(out_valid), 64'hB);
    chk("single_tag0", 64'(out_tag[0 +: TOW]), 64'h25A);
    chk("single_tag3", 64'(out_tag[3*TOW +: TOW]), 64'h25A);
    chk("single_addr1", 64'(out_addr[1*AW +: AW]), 64'(f_addr(2, 1, 8'h5A)));
    chk("single_data3", 64'(out_data[3*32 +: 32]), 64'(f_data(2, 3, 8'h5A)));
    step();
    chk("single_retired", 64'(out_valid), 64'h0);

    // partial acceptance over two cycles
    set_in(1, 4'hF, 8'h11, 1'b1);
    out_ready = 4'h0;
    #1;
    step();
    in_valid = '0;
    out_ready = 4'b0011;
    #1;
    chk("part_c1_valid", 64'(out_valid), 64'hF);
    chk("part_c1_addr2", 64'(out_addr[2*AW +: AW]), 64'(f_addr(1, 2, 8'h11)));
    chk("part_c1_data3", 64'(out_data[3*32 +: 32]), 64'(f_data(1, 3, 8'h11)));
    step();
    out_ready = 4'b1100;
    #1;
    chk("part_c2_valid", 64'(out_valid), 64'hC);
    chk("part_c2_addr2", 64'(out_addr[2*AW +: AW]), 64'(f_addr(1, 2, 8'h11)));
    chk("part_c2_data3", 64'(out_data[3*32 +: 32]), 64'(f_data(1, 3, 8'h11)));
    chk("part_c2_tag2", 64'(out_tag[2*TOW +: TOW]), 64'h111);
    step();
    chk("part_retired", 64'(out_valid), 64'h0);

    // round-robin with all inputs streaming; reset first so rr restarts at 0
    reset = 1'b0;
    step();
    reset = 1'b1;
    tv[0] = '{iv:4'hF, ordy:4'hF, ov:4'h0, ir:4'hF, sel:2'd0};
    tv[1] = '{iv:4'hF, ordy:4'hF, ov:4'hF, ir:4'hF, sel:2'd0};
    tv[2] = '{iv:4'hF, ordy:4'hF, ov:4'hF, ir:4'b0001, sel:2'd1};
    tv[3] = '{iv:4'hF, ordy:4'hF, ov:4'hF, ir:4'b0010, sel:2'd2};
    tv[4] = '{iv:4'hF, ordy:4'hF, ov:4'hF, ir:4'b0100, sel:2'd3};
    tv[5] = '{iv:4'hF, ordy:4'hF, ov:4'hF, ir:4'b1000, sel:2'd0};
    tv[6] = '{iv:4'hF, ordy:4'hF, ov:4'hF, ir:4'b0001, sel:2'd1};
    tv[7] = '{iv:4'hF, ordy:4'hF, ov:4'hF, ir:4'b0010, sel:2'd2};
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NI; i++) set_in(i, 4'hF, 8'h40 + 8'(i), tv[k].iv[i]);
      out_ready = tv[k].ordy;
      #1;
      chk($sformatf("rr%0d_valid", k), 64'(out_valid), 64'(tv[k].ov));
      chk($sformatf("rr%0d_ready", k), 64'(in_ready), 64'(tv[k].ir));
      if (tv[k].ov != 4'h0)
        chk($sformatf("rr%0d_tag", k), 64'(out_tag[0 +: TOW]),
            64'({tv[k].sel, 8'h40 + 8'(tv[k].sel)}));
      step();
    end
    in_valid = '0;
    out_ready = 4'hF;
    for (int k = 0; k < 12; k++) step();
    chk("rr_drained", 64'(out_valid), 64'h0);

    // zero-mask bundles must not occupy FIFO 0 even with the output stalled
    out_ready = 4'h0;
    set_in(0, 4'h0, 8'h77, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("zero%0d_ready", k), 64'(in_ready[0]), 64'h1);
      chk($sformatf("zero%0d_valid", k), 64'(out_valid), 64'h0);
      step();
    end
    in_valid[0] = 1'b0;

    // backpressure: FIFO 1 fills after two accepts, third held until a retire
    set_in(1, 4'b0101, 8'h21, 1'b1);
    #1;
    chk("bp_a_ready", 64'(in_ready[1]), 64'h1);
    step();
    set_in(1, 4'b0101, 8'h22, 1'b1);
    #1;
    chk("bp_b_ready", 64'(in_ready[1]), 64'h1);
    chk("bp_b_valid", 64'(out_valid), 64'h5);
    chk("bp_b_tag", 64'(out_tag[0 +: TOW]), 64'h121);
    step();
    set_in(1, 4'b0101, 8'h23, 1'b1);
    #1;
    chk("bp_c_full", 64'(in_ready[1]), 64'h0);
    chk("bp_c_tag", 64'(out_tag[2*TOW +: TOW]), 64'h121);
    step();
    out_ready = 4'hF;
    #1;
    chk("bp_d_nopass", 64'(in_ready[1]), 64'h0);
    chk("bp_d_valid", 64'(out_valid), 64'h5);
    step();
    #1;
    chk("bp_e_ready", 64'(in_ready[1]), 64'h1);
    chk("bp_e_tag", 64'(out_tag[0 +: TOW]), 64'h122);
    step();
    in_valid = '0;
    #1;
    chk("bp_f_tag", 64'(out_tag[0 +: TOW]), 64'h123);
    chk("bp_f_valid", 64'(out_valid), 64'h5);
    step();
    chk("bp_empty", 64'(out_valid), 64'h0);

    // async reset in the middle of a held bundle
    set_in(3, 4'b0011, 8'h33, 1'b1);
    out_ready = 4'h0;
    #1;
    step();
    in_valid = '0;
    out_ready = 4'b0001;
    #1;
    chk("mid_c1_valid", 64'(out_valid), 64'h3);
    step();
    out_ready = 4'h0;
    #1;
    chk("mid_c2_valid", 64'(out_valid), 64'h2);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_ready", 64'(in_ready), 64'h0);
    step();
    reset = 1'b1;
    out_ready = 4'hF;
    #1;
    chk("mid_rel_valid", 64'(out_valid), 64'h0);
    chk("mid_rel_ready", 64'(in_ready), 64'hF);
    step();
    chk("mid_no_replay", 64'(out_valid), 64'h0);

    // rr pointer back at 0: input 0 wins over input 2
    set_in(0, 4'b0001, 8'hA0, 1'b1);
    set_in(2, 4'b0001, 8'hA2, 1'b1);
    #1;
    step();
    in_valid = '0;
    #1;
    chk("rr0_first_tag", 64'(out_tag[0 +: TOW]), 64'h0A0);
    chk("rr0_first_valid", 64'(out_valid), 64'h1);
    step();
    chk("rr0_second_tag", 64'(out_tag[0 +: TOW]), 64'h2A2);
    step();
    chk("rr0_done", 64'(out_valid), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/vx_dcache_req_arb.md
Name: vx_dcache_req_arb

Overview:
- Multi-requester data-cache request arbiter. Merges NUM_INPUTS request bundles, each up to NUM_REQS lanes wide, onto one NUM_REQS-lane cache request port.
- Each input is buffered in a per-input FIFO. Inputs are arbitrated round-robin.
- The input index is prepended to the tag so the response path can route the reply back.
- Sits between core-side LSU/requester clusters and the dcache bank-select stage.

Parameters:
- NUM_INPUTS, 4, number of requesters (>=1)
- NUM_REQS, 4, lanes per bundle and per output port
- WORD_SIZE, 4, bytes per lane word
- ADDR_WIDTH, 30, word-address width
- TAG_IN_WIDTH, 8, bundle tag width per input
- BUF_DEPTH, 2, per-input FIFO depth in bundles (power of 2, >=2)
- Derived: SEL_BITS = max(1, clog2(NUM_INPUTS)); TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  NUM_INPUTS  bundle valid per input
- in_lane_mask  in  NUM_INPUTS*NUM_REQS  active lanes of bundle
- in_rw  in  NUM_INPUTS*NUM_REQS  1 = write
- in_byteen  in  NUM_INPUTS*NUM_REQS*WORD_SIZE  byte enables
- in_addr  in  NUM_INPUTS*NUM_REQS*ADDR_WIDTH  word addresses
- in_data  in  NUM_INPUTS*NUM_REQS*WORD_SIZE*8  write data
- in_tag  in  NUM_INPUTS*TAG_IN_WIDTH  bundle tag
- in_ready  out  NUM_INPUTS  FIFO i can accept
- out_valid  out  NUM_REQS  per-lane request valid
- out_rw, out_byteen, out_addr, out_data  out  per-lane widths as above  selected bundle fields
- out_tag  out  NUM_REQS*TAG_OUT_WIDTH  {sel, in_tag} replicated per lane
- out_ready  in  NUM_REQS  per-lane cache accept

Behaviour:
- Reset (reset=0, async):
  - all FIFOs empty; sent mask = 0; rr pointer = 0; state IDLE.
  - out_valid = 0, in_ready = 0.
  - After deassertion, in_ready = all ones.
  - Reset mid-transfer discards buffered and partially sent bundles; nothing replays.
- Enqueue:
  - Occurs on in_valid[i] & in_ready[i].
  - in_ready[i] = FIFO i not full; it depends on registered occupancy only.
  - A full FIFO does not accept a push even when it pops in the same cycle (no pass-through).
  - A bundle with all-zero in_lane_mask is accepted and discarded, never enqueued.
- Latency: a bundle enqueued in cycle N is visible on out at cycle N+1 at the earliest. There is no input-to-output bypass.
- FSM:
  - IDLE: grant = first non-empty FIFO at or after rr pointer (wrapping). out_valid[l] = head.mask[l].
    - If granted and all active lanes are accepted this cycle: retire, stay IDLE.
    - Else if granted: latch cur_sel and the accepted lanes into sent, go to HOLD.
  - HOLD: present head of cur_sel with out_valid[l] = mask[l] & ~sent[l]. Set sent bits for lanes where out_valid & out_ready.
    - When (sent | accepted_now) covers mask: retire, go to IDLE.
- Retire:
  - pop head; clear sent; rr pointer = granted index + 1 mod NUM_INPUTS.
  - The next bundle can present in the next cycle with no bubble.
- Stability: once a lane's out_valid rises, that lane's fields stay stable until accepted. The grant never changes while in HOLD.
- out_tag[l] = {granted index (SEL_BITS), head tag}.
- Fields of inactive lanes are don't-care. out_valid for those lanes is 0.
- NUM_INPUTS = 1: SEL_BITS = 1 and the select field is constant 0.
- out_ready on a lane with out_valid = 0 is ignored.

Optional Feature:
- Macro: VX_DCACHE_REQ_ARB_PERF_EN.
- When defined, the block adds output ports:
  - perf_stall_cycles[63:0]: counts cycles with any out_valid[l] & ~out_ready[l].
  - perf_bundles[63:0]: counts retired bundles.
  - Both counters reset to 0 and saturate at all-ones.
- When not defined, these ports and counters do not exist. Functional behaviour is identical either way.

Test Plan:
- Reset then single bundle: input 2, mask 4'b1011, tag 8'h5A, out_ready all 1 -> out_valid = 4'b1011 exactly one cycle after enqueue; out_tag = {2'd2, 8'h5A}; FIFO 2 empty next cycle.
- Partial acceptance: mask 4'b1111, out_ready 4'b0011 then 4'b1100 -> cycle 1 out_valid = 1111; cycle 2 out_valid = 1100; retire after cycle 2; addr/data of lanes 2-3 unchanged across both cycles.
- Round-robin fairness: inputs 0-3 continuously valid, out_ready all 1 -> grants 0,1,2,3,0,... one bundle per cycle with no bubbles.
- Backpressure/full: BUF_DEPTH = 2, out_ready = 0, input 1 pushes 3 bundles -> in_ready[1] = 0 after 2 accepts; the third bundle is held; accepted after one retire.
- Zero mask: input 0 pushes mask 0 -> in_ready stays 1; no out_valid; FIFO 0 occupancy stays 0.
- Reset mid-HOLD: assert reset after lane 0 of 4'b0011 is accepted -> out_valid = 0 immediately (async); after release, no output until new input; rr pointer = 0.
